// File: rtl/odd_seq_checker_pkg.sv
// Shared constants for the odd-sequence checker: FSM state encodings and
// counter direction values.
package odd_seq_checker_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACQ  = 2'd1;
   localparam logic [1:0] S_LOCK = 2'd2;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/odd_seq_checker_odd_step.sv
// Next value of the odd up/down counter: +2 going up, -2 going down,
// wrapping modulo 2**WIDTH so 15 -> 1 and 1 -> 15 for WIDTH=4.
module odd_step
   import odd_seq_checker_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_dir,
   output logic [WIDTH-1:0] o_next
);

   assign o_next = (i_dir == DIR_UP) ? i_q + WIDTH'(2) : i_q - WIDTH'(2);

endmodule

// File: rtl/odd_seq_checker.sv
// Monitor for the odd up/down counter: acquires lock after LOCK_N correct
// steps, then flags every violation and keeps a saturating error count.
module odd_seq_checker
   import odd_seq_checker_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int ERRW   = 8,
   parameter int LOCK_N = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Q,
   input  logic             Y,
   output logic             locked,
   output logic             err,
   output logic             dir_chg,
   output logic [WIDTH-1:0] expected,
   output logic [ERRW-1:0]  err_count
);

   localparam int CNTW = $clog2(LOCK_N + 1);

   logic [1:0]       r_state;
   logic [CNTW-1:0]  r_step_cnt;
   logic             r_prev_y;
   logic [WIDTH-1:0] r_pred;
   logic             r_locked;
   logic             r_err;
   logic             r_dir_chg;
   logic [WIDTH-1:0] r_expected;
   logic [ERRW-1:0]  r_err_count;

   logic [WIDTH-1:0] w_step;
   logic             w_match;
   logic [1:0]       w_state_nxt;
   logic [CNTW-1:0]  w_cnt_nxt;
   logic [CNTW-1:0]  w_cnt_inc;
   logic             w_viol;
   logic             w_dir_chg;

   // f(Q,Y) registered into r_pred is next cycle's f(prev_q, prev_y), so a
   // single step instance serves both the check and the expected output.
   odd_step #(.WIDTH(WIDTH)) u_step (
      .i_q    (Q),
      .i_dir  (Y),
      .o_next (w_step)
   );

   assign w_match   = Q[0] && (Q == r_pred);
   assign w_cnt_inc = r_step_cnt + CNTW'(1);
   assign w_dir_chg = (r_state != S_IDLE) && (Y != r_prev_y);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_step_cnt;
      w_viol      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Q[0]) begin
               w_state_nxt = S_ACQ;
               w_cnt_nxt   = '0;
            end
         end
         S_ACQ: begin
            if (w_match) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == CNTW'(LOCK_N)) w_state_nxt = S_LOCK;
            end else begin
               w_cnt_nxt   = '0;
               w_state_nxt = Q[0] ? S_ACQ : S_IDLE;
            end
         end
         S_LOCK: begin
            if (!w_match) begin
               w_viol      = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = Q[0] ? S_ACQ : S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      if (rst) begin
         r_state     <= S_IDLE;
         r_step_cnt  <= '0;
         r_prev_y    <= 1'b0;
         r_pred      <= '0;
         r_locked    <= 1'b0;
         r_err       <= 1'b0;
         r_dir_chg   <= 1'b0;
         r_expected  <= '0;
         r_err_count <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_step_cnt <= w_cnt_nxt;
         r_prev_y   <= Y;
         r_pred     <= w_step;
         r_locked   <= (w_state_nxt == S_LOCK);
         r_expected <= (w_state_nxt == S_LOCK) ? w_step : '0;
         r_err      <= w_viol;
         r_dir_chg  <= w_dir_chg;
         if (w_viol && (r_err_count != '1)) r_err_count <= r_err_count + ERRW'(1);
      end
   end

   assign locked    = r_locked;
   assign err       = r_err;
   assign dir_chg   = r_dir_chg;
   assign expected  = r_expected;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Directed bench for odd_seq_checker: lock-up, wrap, reversal, violations,
// saturation of the error count and reset while locked.
module tb_odd_seq_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] Q;
   logic       Y;
   logic       locked;
   logic       err;
   logic       dir_chg;
   logic [3:0] expected;
   logic [7:0] err_count;

   int n_cmp = 0;
   int n_bad = 0;

   odd_seq_checker #(.WIDTH(4), .ERRW(8), .LOCK_N(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .Q         (Q),
      .Y         (Y),
      .locked    (locked),
      .err       (err),
      .dir_chg   (dir_chg),
      .expected  (expected),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one sample, let the DUT clock it, then settle before checking.
   task automatic step(input logic [3:0] q, input logic y);
      Q = q;
      Y = y;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] q_cur;
      logic [3:0] bad;
      int         exp_cnt;

      // 1: reset held two cycles
      rst = 1'b1;
      Q   = 4'd1;
      Y   = 1'b0;
      step(4'd1, 1'b0);
      step(4'd1, 1'b0);
      check("rst_locked",   locked,    0);
      check("rst_err",      err,       0);
      check("rst_err_cnt",  err_count, 0);
      check("rst_expected", expected,  0);
      check("rst_dir_chg",  dir_chg,   0);
      rst = 1'b0;

      // 2: acquire while counting up
      step(4'd1, 1'b0);
      check("acq1_locked", locked, 0);
      step(4'd3, 1'b0);
      check("acq3_locked", locked, 0);
      step(4'd5, 1'b0);
      check("acq5_locked", locked, 1);
      check("acq5_expected", expected, 7);
      step(4'd7, 1'b0);
      check("lock7_expected", expected, 9);
      check("lock7_err", err, 0);

      // 3: wrap 15 -> 1
      step(4'd9, 1'b0);
      step(4'd11, 1'b0);
      step(4'd13, 1'b0);
      step(4'd15, 1'b0);
      check("wrap15_expected", expected, 1);
      step(4'd1, 1'b0);
      check("wrap1_locked", locked, 1);
      check("wrap1_err", err, 0);
      check("wrap1_expected", expected, 3);
      step(4'd3, 1'b0);
      step(4'd5, 1'b0);
      step(4'd7, 1'b0);

      // 4: direction reversal at 9
      step(4'd9, 1'b1);
      check("rev9_dir_chg", dir_chg, 1);
      check("rev9_locked", locked, 1);
      check("rev9_expected", expected, 7);
      step(4'd7, 1'b1);
      check("rev7_dir_chg", dir_chg, 0);
      check("rev7_err", err, 0);
      check("rev7_expected", expected, 5);
      step(4'd5, 1'b1);
      check("rev5_locked", locked, 1);
      check("rev5_expected", expected, 3);

      // 5: skip violation, relock attempt, even value, held value, even while locked
      step(4'd9, 1'b1);
      check("skip_err", err, 1);
      check("skip_err_cnt", err_count, 1);
      check("skip_locked", locked, 0);
      check("skip_expected", expected, 0);
      step(4'd7, 1'b1);
      check("skip_next_err", err, 0);
      check("skip_next_locked", locked, 0);
      step(4'd6, 1'b1);
      check("even_acq_err", err, 0);
      check("even_acq_cnt", err_count, 1);
      step(4'd5, 1'b1);
      step(4'd3, 1'b1);
      check("relock_pending", locked, 0);
      step(4'd1, 1'b1);
      check("relock_locked", locked, 1);
      check("relock_expected", expected, 15);
      step(4'd1, 1'b1);
      check("hold_err", err, 1);
      check("hold_err_cnt", err_count, 2);
      check("hold_locked", locked, 0);
      step(4'd15, 1'b1);
      step(4'd13, 1'b1);
      check("relock2_expected", expected, 11);
      step(4'd12, 1'b1);
      check("even_lock_err", err, 1);
      check("even_lock_cnt", err_count, 3);
      check("even_lock_locked", locked, 0);
      step(4'd12, 1'b1);
      check("idle_even_err", err, 0);
      step(4'd12, 1'b0);
      check("idle_dir_chg", dir_chg, 0);
      check("idle_err_cnt", err_count, 3);

      // 6: saturate the error counter, then reset while locked
      step(4'd1, 1'b0);
      step(4'd3, 1'b0);
      step(4'd5, 1'b0);
      check("sat_start_locked", locked, 1);
      q_cur   = 4'd5;
      exp_cnt = 3;
      for (int i = 0; i < 260; i++) begin
         bad = q_cur + 4'd4;
         step(bad, 1'b0);
         exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
         check("sat_err", err, 1);
         check("sat_err_cnt", err_count, exp_cnt);
         step(bad + 4'd2, 1'b0);
         step(bad + 4'd4, 1'b0);
         q_cur = bad + 4'd4;
      end
      check("sat_final_cnt", err_count, 255);
      check("sat_final_locked", locked, 1);
      check("sat_final_expected", expected, q_cur + 4'd2);

      rst = 1'b1;
      step(q_cur + 4'd2, 1'b0);
      check("midrst_locked", locked, 0);
      check("midrst_err_cnt", err_count, 0);
      check("midrst_err", err, 0);
      check("midrst_expected", expected, 0);
      rst = 1'b0;
      step(4'd3, 1'b0);
      check("post_rst_locked", locked, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
